// File: rtl/bus_xfer_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// bus_xfer_ctrl_pkg
// Shared definitions for the bus transfer controller slice.
//   - default sizes for the register bank, requester count and select width
//   - transfer sequencer state encoding
//   - idx_width(): width of an index into n items, never less than 1 bit
// ----------------------------------------------------------------------------
package bus_xfer_ctrl_pkg;

   localparam int DEF_NUM_REGS = 4;
   localparam int DEF_NUM_REQ  = 4;
   localparam int DEF_SEL_W    = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_LATCH = 2'd2,
      ST_TURN  = 2'd3
   } state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_xfer_ctrl_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at ptr and
// walks ptr, ptr+1, ... modulo N; the first asserted request wins.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  highest-priority requester for this decision (0..N-1)
//   grant out N   one-hot winner, zero when no request
//   idx   out IW  encoded winner, 0 when no request
//   valid out 1   at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter
   import bus_xfer_ctrl_pkg::*;
#(
   parameter  int N  = DEF_NUM_REQ,
   localparam int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          valid
);

   always_comb begin
      int j;
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!valid && req[j]) begin
            valid    = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// bus_xfer_ctrl
// Sequences register-to-register transfers over one shared tri-state bus.
// A round-robin arbiter picks one posted (src, dst) transfer in IDLE; the
// sequencer then drives en[src] (DRIVE), keeps it and strobes load[dst]
// (LATCH), and releases the bus for one turnaround cycle (TURN) before the
// next grant can be made. So there is always at least one all-en-low cycle
// between two different bus drivers.
// Ports:
//   clk      in  1              rising-edge clock
//   clr      in  1              asynchronous active-high reset
//   req      in  NUM_REQ        pending-transfer flags
//   req_src  in  NUM_REQ*SEL_W  source select of requester i at [i*SEL_W +: SEL_W]
//   req_dst  in  NUM_REQ*SEL_W  destination select of requester i
//   en       out NUM_REGS       tri-state enables, one-hot or zero
//   load     out NUM_REGS       load strobes, one-hot or zero
//   gnt      out NUM_REQ        one-hot pulse in DRIVE: request accepted
//   done     out NUM_REQ        one-hot pulse in TURN: transfer complete
//   busy     out 1              high in every state except IDLE
// All outputs come straight from flops; they are precomputed from the next
// state so they line up with the state they belong to.
// SEL_W must satisfy 2**SEL_W >= NUM_REGS. Selects >= NUM_REGS run the full
// sequence with en/load held low.
// ----------------------------------------------------------------------------
module bus_xfer_ctrl
   import bus_xfer_ctrl_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int SEL_W    = DEF_SEL_W
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*SEL_W-1:0] req_src,
   input  logic [NUM_REQ*SEL_W-1:0] req_dst,
   output logic [NUM_REGS-1:0]      en,
   output logic [NUM_REGS-1:0]      load,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [NUM_REQ-1:0]       done,
   output logic                     busy
);

   localparam int REQ_W = idx_width(NUM_REQ);

   state_t              state_reg, state_next;
   logic [SEL_W-1:0]    src_reg, src_next;
   logic [SEL_W-1:0]    dst_reg, dst_next;
   logic [REQ_W-1:0]    win_reg, win_next;
   logic [REQ_W-1:0]    ptr_reg, ptr_next;

   logic [NUM_REGS-1:0] en_reg, en_next;
   logic [NUM_REGS-1:0] load_reg, load_next;
   logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
   logic [NUM_REQ-1:0]  done_reg, done_next;
   logic                busy_reg, busy_next;

   logic [NUM_REQ-1:0]  arb_grant;
   logic [REQ_W-1:0]    arb_idx;
   logic                arb_valid;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req   (req),
      .ptr   (ptr_reg),
      .grant (arb_grant),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   // Next-state and capture logic. Requests only matter in IDLE.
   always_comb begin
      state_next = state_reg;
      src_next   = src_reg;
      dst_next   = dst_reg;
      win_next   = win_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         ST_IDLE: begin
            if (arb_valid) begin
               state_next = ST_DRIVE;
               src_next   = req_src[arb_idx*SEL_W +: SEL_W];
               dst_next   = req_dst[arb_idx*SEL_W +: SEL_W];
               win_next   = arb_idx;
               ptr_next   = (arb_idx == REQ_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end
         end
         ST_DRIVE: state_next = ST_LATCH;
         ST_LATCH: state_next = ST_TURN;
         ST_TURN:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Output decode from the next state, registered below. An out-of-range
   // select never matches any gi, which keeps en/load low for that transfer.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_dec
         assign en_next[gi]   = ((state_next == ST_DRIVE) || (state_next == ST_LATCH))
                                && (src_next == SEL_W'(gi));
         assign load_next[gi] = (state_next == ST_LATCH) && (dst_next == SEL_W'(gi));
      end
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req_dec
         assign done_next[gi] = (state_next == ST_TURN) && (win_next == REQ_W'(gi));
      end
   endgenerate

   // The arbiter grant is zero when nothing is requested, so this pulses
   // exactly on the IDLE -> DRIVE edge.
   assign gnt_next  = (state_reg == ST_IDLE) ? arb_grant : '0;
   assign busy_next = (state_next != ST_IDLE);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_reg <= ST_IDLE;
         src_reg   <= '0;
         dst_reg   <= '0;
         win_reg   <= '0;
         ptr_reg   <= '0;
         en_reg    <= '0;
         load_reg  <= '0;
         gnt_reg   <= '0;
         done_reg  <= '0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         src_reg   <= src_next;
         dst_reg   <= dst_next;
         win_reg   <= win_next;
         ptr_reg   <= ptr_next;
         en_reg    <= en_next;
         load_reg  <= load_next;
         gnt_reg   <= gnt_next;
         done_reg  <= done_next;
         busy_reg  <= busy_next;
      end
   end

   assign en   = en_reg;
   assign load = load_reg;
   assign gnt  = gnt_reg;
   assign done = done_reg;
   assign busy = busy_reg;

endmodule
